// File: rtl/prga_pkg.sv
// Shared types and constants for the RC4 pseudo-random generation / decrypt FSM.
package prga_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_INC, S_RD_SI, S_WT_SI, S_LD_SI, S_RD_SJ, S_WT_SJ, S_LD_SJ,
        S_WR_I, S_WR_J, S_RD_F, S_WT_F, S_LD_F, S_WR_D, S_NEXT, S_DONE
    } state_t;

    localparam int         MSG_LEN_DEFAULT = 32;
    localparam logic [7:0] CHAR_LO         = 8'h61;
    localparam logic [7:0] CHAR_HI         = 8'h7A;
    localparam logic [7:0] CHAR_SPACE      = 8'h20;

    function automatic bit is_valid_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SPACE);
    endfunction

endpackage

// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA phase: swaps S, fetches keystream byte, XORs with ROM ciphertext into decrypt RAM.
// Optional plaintext check enabled by defining PRGA_VALID_CHECK_EN.
module prga_decrypt_fsm
    import prga_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] q,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       wren,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_q,
    output logic [7:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren,
    output logic       finish,
    output logic       key_invalid
);

    localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

    state_t     r_state, w_next;
    logic [7:0] r_i, r_j, r_k, r_si, r_sj, r_f;
    logic [7:0] r_address, r_data, r_rom_address, r_dec_address, r_dec_data;
    logic       r_wren, r_dec_wren;
    logic [7:0] w_plain;
    logic       w_stop;

    assign w_plain = r_f ^ rom_q;

`ifdef PRGA_VALID_CHECK_EN
    logic r_key_invalid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                           r_key_invalid <= 1'b0;
        else if (r_state == S_IDLE && start)    r_key_invalid <= 1'b0;
        else if (r_state == S_WR_D && !is_valid_char(w_plain)) r_key_invalid <= 1'b1;
    end

    // A rejected byte ends the run early; the bad byte itself is still written.
    assign w_stop      = (r_k == K_LAST) || r_key_invalid;
    assign key_invalid = r_key_invalid;
`else
    assign w_stop      = (r_k == K_LAST);
    assign key_invalid = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_INC;
            S_NEXT:  w_next = w_stop ? S_DONE : S_INC;
            S_DONE:  w_next = S_IDLE;
            default: w_next = state_t'(r_state + 4'd1);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            r_si          <= '0;
            r_sj          <= '0;
            r_f           <= '0;
            r_address     <= '0;
            r_data        <= '0;
            r_wren        <= 1'b0;
            r_rom_address <= '0;
            r_dec_address <= '0;
            r_dec_data    <= '0;
            r_dec_wren    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_i <= '0;
                    r_j <= '0;
                    r_k <= '0;
                end
                S_INC:   r_i <= r_i + 8'd1;
                S_RD_SI: r_address <= r_i;
                S_LD_SI: begin
                    r_si <= q;
                    r_j  <= r_j + q;
                end
                S_RD_SJ: r_address <= r_j;
                S_LD_SJ: r_sj <= q;
                S_WR_I: begin
                    r_address <= r_i;
                    r_data    <= r_sj;
                    r_wren    <= 1'b1;
                end
                S_WR_J: begin
                    r_address <= r_j;
                    r_data    <= r_si;
                    r_wren    <= 1'b1;
                end
                // Pre-swap si+sj equals post-swap S[i]+S[j], so no re-read is needed.
                S_RD_F: begin
                    r_wren        <= 1'b0;
                    r_address     <= r_si + r_sj;
                    r_rom_address <= r_k;
                end
                S_LD_F: r_f <= q;
                S_WR_D: begin
                    r_dec_address <= r_k;
                    r_dec_data    <= w_plain;
                    r_dec_wren    <= 1'b1;
                end
                S_NEXT: begin
                    r_dec_wren <= 1'b0;
                    if (!w_stop) r_k <= r_k + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign address     = r_address;
    assign data        = r_data;
    assign wren        = r_wren;
    assign rom_address = r_rom_address;
    assign dec_address = r_dec_address;
    assign dec_data    = r_dec_data;
    assign dec_wren    = r_dec_wren;
    assign finish      = (r_state == S_DONE);

endmodule
